// File: rtl/router_out_drain.sv
// Read-side drain controller for a router output FIFO: pops bytes, presents them
// with a valid/read_enb handshake, tracks packet framing and flushes on a stalled sink.
module router_out_drain #(
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 5
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       fifo_empty,
   input  logic [8:0] fifo_dout,
   output logic       fifo_re,
   input  logic       read_enb,
   output logic [7:0] data_out,
   output logic       vld_out,
   output logic       sop,
   output logic       eop,
   output logic       soft_rst,
   output logic       pkt_err
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} state_t;

   state_t           state_q, state_d;
   logic [7:0]       data_q, data_d;
   logic             sop_q, sop_d;
   logic             eop_q, eop_d;
   logic             err_q, err_d;
   logic [6:0]       rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fifo_re_c;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         data_q  <= 8'h00;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         err_q   <= 1'b0;
         rem_q   <= 7'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         err_q   <= err_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      err_d     = 1'b0;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      fifo_re_c = 1'b0;
      case (state_q)
         IDLE: begin
            fifo_re_c = !fifo_empty;
            if (!fifo_empty) state_d = REQ;
         end
         REQ: begin
            data_d  = fifo_dout[7:0];
            sop_d   = fifo_dout[8];
            cnt_d   = '0;
            state_d = HOLD;
            // Header length counts payload bytes; the extra one is the parity byte.
            if (fifo_dout[8]) begin
               rem_d = {1'b0, fifo_dout[7:2]} + 7'd1;
               err_d = (rem_q != 7'd0);
               eop_d = 1'b0;
            end else if (rem_q == 7'd0) begin
               err_d = 1'b1;
               eop_d = 1'b0;
            end else begin
               rem_d = rem_q - 7'd1;
               eop_d = (rem_q == 7'd1);
            end
         end
         HOLD: begin
            if (read_enb) begin
               if (!fifo_empty) begin
                  fifo_re_c = 1'b1;
                  state_d   = REQ;
               end else begin
                  state_d = IDLE;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = FLUSH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FLUSH: begin
            rem_d   = 7'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read enable is combinational from the flags, so reset must mask it explicitly.
   assign fifo_re  = rstn & fifo_re_c;
   assign vld_out  = (state_q == HOLD);
   assign soft_rst = (state_q == FLUSH);
   assign data_out = data_q;
   assign sop      = vld_out & sop_q;
   assign eop      = vld_out & eop_q;
   assign pkt_err  = err_q;

endmodule

// File: tb/tb_router_out_drain.sv
// Bench for router_out_drain: a queue-based FIFO model feeds the DUT while a
// byte-stream reference model is compared against every output on every cycle.
module tb_router_out_drain;

   localparam int TIMEOUT = 30;

   logic       clk = 1'b0;
   logic       rstn;
   logic       fifo_empty = 1'b1;
   logic [8:0] fifo_dout = 9'h000;
   logic       fifo_re;
   logic       read_enb = 1'b0;
   logic [7:0] data_out;
   logic       vld_out, sop, eop, soft_rst, pkt_err;

   logic       load_en = 1'b0;
   int         load_n = 0;
   logic [8:0] load_arr [0:7];
   logic [8:0] fifo_q [$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit saw_err, saw_soft;

   bit       m_vld, m_sop, m_eop, m_err, m_flush, m_fetch;
   bit [7:0] m_data;
   int       m_rem, m_wait;

   router_out_drain #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_re(fifo_re), .read_enb(read_enb), .data_out(data_out), .vld_out(vld_out),
      .sop(sop), .eop(eop), .soft_rst(soft_rst), .pkt_err(pkt_err)
   );

   always #5 clk = ~clk;

   // FIFO model: data appears the cycle after a read, soft_rst empties it at the next edge.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fifo_q.delete();
         fifo_dout  <= 9'h000;
         fifo_empty <= 1'b1;
      end else begin
         if (soft_rst) fifo_q.delete();
         else if (fifo_re && fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
         if (load_en) for (int i = 0; i < load_n; i++) fifo_q.push_back(load_arr[i]);
         fifo_empty <= (fifo_q.size() == 0);
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_vld = 0; m_sop = 0; m_eop = 0; m_err = 0; m_flush = 0; m_fetch = 0;
      m_data = 8'h00; m_rem = 0; m_wait = 0;
   endtask

   // One clock: compare every output against the reference model, then advance the model.
   task automatic clock_cycle();
      logic exp_re;
      @(negedge clk);
      cyc++;
      if (!rstn) begin
         model_reset();
         check_output("rst_vld", vld_out, 0);
         check_output("rst_re", fifo_re, 0);
         check_output("rst_soft", soft_rst, 0);
         check_output("rst_data", data_out, 0);
         check_output("rst_sop", sop, 0);
         check_output("rst_eop", eop, 0);
         check_output("rst_err", pkt_err, 0);
      end else begin
         exp_re = !m_flush && !m_fetch && !fifo_empty && (!m_vld || read_enb);
         check_output("cyc_vld", vld_out, m_vld);
         check_output("cyc_data", data_out, m_data);
         check_output("cyc_sop", sop, m_vld & m_sop);
         check_output("cyc_eop", eop, m_vld & m_eop);
         check_output("cyc_err", pkt_err, m_err);
         check_output("cyc_soft", soft_rst, m_flush);
         check_output("cyc_re", fifo_re, exp_re);
         if (pkt_err === 1'b1) saw_err = 1;
         if (soft_rst === 1'b1) saw_soft = 1;
         m_err = 0;
         if (m_flush) begin
            m_flush = 0;
            m_rem   = 0;
         end else if (m_fetch) begin
            m_fetch = 0;
            m_data  = fifo_dout[7:0];
            m_sop   = fifo_dout[8];
            m_eop   = 0;
            if (fifo_dout[8]) begin
               m_err = (m_rem != 0);
               m_rem = int'(fifo_dout[7:2]) + 1;
            end else if (m_rem == 0) begin
               m_err = 1;
            end else begin
               m_rem = m_rem - 1;
               m_eop = (m_rem == 0);
            end
            m_vld  = 1;
            m_wait = 0;
         end else if (m_vld) begin
            if (read_enb) begin
               m_vld   = 0;
               m_fetch = !fifo_empty;
            end else begin
               m_wait++;
               if (m_wait == TIMEOUT) begin
                  m_vld   = 0;
                  m_flush = 1;
               end
            end
         end else begin
            m_fetch = !fifo_empty;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input int n, input logic [8:0] v [0:7]);
      load_n = n;
      for (int i = 0; i < 8; i++) load_arr[i] = v[i];
      load_en = 1'b1;
      clock_cycle();
      load_en = 1'b0;
   endtask

   task automatic wait_vld();
      int k = 0;
      while (vld_out !== 1'b1 && k < 20) begin
         clock_cycle();
         k++;
      end
      check_output("wait_vld", vld_out, 1);
   endtask

   task automatic expect_present(input string name, input logic [7:0] b, input logic s,
                                 input logic e, input logic er, output int at);
      wait_vld();
      check_output({name, "_data"}, data_out, b);
      check_output({name, "_sop"}, sop, s);
      check_output({name, "_eop"}, eop, e);
      check_output({name, "_err"}, pkt_err, er);
      at = cyc;
      clock_cycle();
   endtask

   initial begin
      int t [0:4];
      int r;
      int k;
      logic [7:0] exp_b [0:4];
      exp_b[0] = 8'h0D; exp_b[1] = 8'hA1; exp_b[2] = 8'hA2; exp_b[3] = 8'hA3; exp_b[4] = 8'h0E;
      model_reset();

      $display("[TB] reset");
      rstn = 1'b1;
      #1 rstn = 1'b0;
      #2;
      check_output("async_rst_vld", vld_out, 0);
      check_output("async_rst_data", data_out, 0);
      check_output("async_rst_soft", soft_rst, 0);
      clock_cycle();
      clock_cycle();
      rstn = 1'b1;
      clock_cycle();
      clock_cycle();

      $display("[TB] single packet");
      saw_err = 0; saw_soft = 0;
      read_enb = 1'b1;
      apply_stimulus(5, '{9'h10D, 9'h0A1, 9'h0A2, 9'h0A3, 9'h00E, 9'h0, 9'h0, 9'h0});
      for (int i = 0; i < 5; i++)
         expect_present("pkt1", exp_b[i], i == 0, i == 4, 1'b0, t[i]);
      for (int i = 1; i < 5; i++) check_output("pkt1_spacing", t[i] - t[i-1], 2);
      clock_cycle();
      check_output("pkt1_empty", fifo_empty, 1);
      check_output("pkt1_no_err", saw_err, 0);
      check_output("pkt1_no_soft", saw_soft, 0);

      $display("[TB] backpressure");
      saw_soft = 0;
      apply_stimulus(5, '{9'h10D, 9'h0A1, 9'h0A2, 9'h0A3, 9'h00E, 9'h0, 9'h0, 9'h0});
      expect_present("bp", 8'h0D, 1'b1, 1'b0, 1'b0, r);
      expect_present("bp", 8'hA1, 1'b0, 1'b0, 1'b0, r);
      read_enb = 1'b0;
      clock_cycle();
      for (int i = 0; i < 10; i++) begin
         check_output("bp_hold_vld", vld_out, 1);
         check_output("bp_hold_data", data_out, 8'hA2);
         clock_cycle();
      end
      read_enb = 1'b1;
      expect_present("bp", 8'hA2, 1'b0, 1'b0, 1'b0, r);
      expect_present("bp", 8'hA3, 1'b0, 1'b0, 1'b0, r);
      expect_present("bp", 8'h0E, 1'b0, 1'b1, 1'b0, r);
      check_output("bp_no_soft", saw_soft, 0);

      $display("[TB] timeout");
      read_enb = 1'b0;
      apply_stimulus(2, '{9'h10D, 9'h0A1, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
      wait_vld();
      r = cyc;
      k = 0;
      while (soft_rst !== 1'b1 && k < 40) begin
         clock_cycle();
         k++;
      end
      check_output("to_latency", cyc - r, 30);
      check_output("to_flush_vld", vld_out, 0);
      check_output("to_flush_re", fifo_re, 0);
      clock_cycle();
      check_output("to_soft_pulse", soft_rst, 0);
      check_output("to_fifo_flushed", fifo_empty, 1);
      check_output("to_idle_re", fifo_re, 0);
      clock_cycle();

      $display("[TB] framing errors");
      read_enb = 1'b1;
      apply_stimulus(6, '{9'h109, 9'h0B1, 9'h105, 9'h0C1, 9'h0C2, 9'h077, 9'h0, 9'h0});
      expect_present("fr", 8'h09, 1'b1, 1'b0, 1'b0, r);
      expect_present("fr", 8'hB1, 1'b0, 1'b0, 1'b0, r);
      expect_present("fr_hdr2", 8'h05, 1'b1, 1'b0, 1'b1, r);
      expect_present("fr", 8'hC1, 1'b0, 1'b0, 1'b0, r);
      expect_present("fr", 8'hC2, 1'b0, 1'b1, 1'b0, r);
      expect_present("fr_orphan", 8'h77, 1'b0, 1'b0, 1'b1, r);

      $display("[TB] empty gap");
      apply_stimulus(2, '{9'h10D, 9'h0A1, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
      expect_present("gap", 8'h0D, 1'b1, 1'b0, 1'b0, r);
      expect_present("gap", 8'hA1, 1'b0, 1'b0, 1'b0, r);
      for (int i = 0; i < 5; i++) begin
         check_output("gap_idle_vld", vld_out, 0);
         check_output("gap_idle_re", fifo_re, 0);
         clock_cycle();
      end
      apply_stimulus(3, '{9'h0A2, 9'h0A3, 9'h00E, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
      expect_present("gap", 8'hA2, 1'b0, 1'b0, 1'b0, r);
      expect_present("gap", 8'hA3, 1'b0, 1'b0, 1'b0, r);
      expect_present("gap", 8'h0E, 1'b0, 1'b1, 1'b0, r);

      $display("[TB] async reset mid-packet");
      read_enb = 1'b0;
      apply_stimulus(3, '{9'h105, 9'h0D1, 9'h0D2, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
      wait_vld();
      read_enb = 1'b1;
      #2 rstn = 1'b0;
      #1;
      check_output("ar_vld", vld_out, 0);
      check_output("ar_re", fifo_re, 0);
      check_output("ar_soft", soft_rst, 0);
      check_output("ar_data", data_out, 0);
      check_output("ar_sop", sop, 0);
      clock_cycle();
      clock_cycle();
      rstn = 1'b1;
      saw_err = 0;
      apply_stimulus(2, '{9'h101, 9'h0E1, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
      expect_present("ar_pkt", 8'h01, 1'b1, 1'b0, 1'b0, r);
      expect_present("ar_pkt", 8'hE1, 1'b0, 1'b1, 1'b0, r);
      check_output("ar_no_err", saw_err, 0);
      clock_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/router_out_drain.md
Name: router_out_drain

Overview:
- Read-side controller for one router output FIFO (16x9 entries; bit 8 = header flag, bits 7:0 = byte).
- Pops bytes from the FIFO and presents them to the destination port with a valid/read_enb handshake.
- Tracks packet boundaries from the header length field and raises sop/eop.
- If the destination does not consume a presented byte within TIMEOUT cycles, pulses soft_rst to flush the FIFO.

Parameters:
- TIMEOUT, 30, cycles a byte may stay presented unconsumed before soft reset.
- CNT_W, 5, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  9  FIFO read data {hdr_flag, byte}; valid the cycle after fifo_re.
- fifo_re  out  1  FIFO read enable, one-cycle pulse per byte.
- read_enb  in  1  destination consumes the presented byte when high with vld_out.
- data_out  out  8  presented byte.
- vld_out  out  1  data_out valid.
- sop  out  1  presented byte is a header (valid with vld_out).
- eop  out  1  presented byte is the last (parity) byte of the packet.
- soft_rst  out  1  one-cycle FIFO flush pulse on timeout.
- pkt_err  out  1  one-cycle pulse on framing error.

Behaviour:
- Async reset: state IDLE. All outputs 0, including data_out = 8'h00. Remaining counter and timeout counter are 0.
- FSM states are IDLE, REQ, HOLD, FLUSH.
- IDLE:
  - fifo_re = !fifo_empty.
  - If fifo_re, go to REQ.
- REQ:
  - Capture fifo_dout into data_out and sop = fifo_dout[8].
  - Go to HOLD. vld_out = 1 from the next cycle.
- HOLD:
  - vld_out = 1. data_out, sop and eop are held stable until consumed.
  - Consume condition: read_enb = 1. On consume:
    - If !fifo_empty: assert fifo_re in the same cycle and go to REQ. vld_out is 0 during REQ, so sustained throughput is 1 byte per 2 cycles.
    - Otherwise go to IDLE.
  - Timeout counter clears on entry to HOLD and increments each HOLD cycle with read_enb = 0.
  - When the counter reaches TIMEOUT-1 with read_enb = 0, go to FLUSH.
- FLUSH (one cycle):
  - soft_rst = 1, vld_out = 0, fifo_re = 0.
  - Remaining counter clears; next state IDLE.
  - A fifo_empty that is still low during FLUSH is ignored; the FIFO empties in the following cycle.
- Packet tracking, on REQ capture:
  - Header byte: remaining = byte[7:2] + 1 (payload plus parity). If remaining was nonzero beforehand, pulse pkt_err and restart the count from the new header.
  - Non-header byte with remaining = 0: pulse pkt_err. The byte is still presented; sop = 0 and eop = 0.
  - Non-header byte otherwise: remaining decrements by 1. eop = 1 when the post-decrement value is 0.
  - Header with length field 0: remaining = 1, so the next byte is parity with eop = 1.
- Remaining counter is 7 bits, so there is no overflow for a length of 63.
- data_out holds its last value when vld_out = 0. It is never driven to Z.
- read_enb with vld_out = 0 is ignored.
- Reset mid-packet aborts immediately; no partial state is retained.

Test Plan:
- Single packet, read_enb tied high:
  - Stimulus: FIFO holds {1,8'h0D}, {0,8'hA1}, {0,8'hA2}, {0,8'hA3}, {0,8'h0E}.
  - Required: 5 bytes out in order, 2 cycles apart. sop = 1 on 8'h0D only; eop = 1 on 8'h0E only. FIFO ends empty; no pkt_err, no soft_rst.
- Backpressure:
  - Stimulus: same packet; read_enb low for 10 cycles on byte 8'hA2.
  - Required: data_out = 8'hA2 and vld_out = 1 held for all 10 cycles, then normal completion with no soft_rst.
- Timeout:
  - Stimulus: header 8'h0D presented, read_enb held low.
  - Required: soft_rst = 1 for exactly one cycle 30 cycles after vld_out rises; vld_out = 0 in that cycle. FSM is in IDLE after; fifo_re is not asserted in the FLUSH cycle.
- Framing errors:
  - Stimulus: header 8'h09 (length 2), one payload byte, then header 8'h05.
  - Required: pkt_err pulses on the second header. Remaining restarts at 2; eop is on the byte 2 bytes after 8'h05.
- Empty gaps:
  - Stimulus: FIFO goes empty mid-packet for 5 cycles.
  - Required: FSM is in IDLE with vld_out = 0 and no timeout counting. On refill, resumes with the correct remaining count and eop placement.
- Async reset:
  - Stimulus: rstn asserted low mid-HOLD.
  - Required: vld_out, fifo_re, soft_rst, data_out and sop go to 0 without waiting for a clk edge. The first packet after release reports sop correctly and no pkt_err.
